// File: rtl/vga_pkg.sv
// Shared 800x600@60 raster timing constants for the timing generator and the drawing stages.
package vga_pkg;

   localparam int unsigned H_ACTIVE = 800;
   localparam int unsigned H_FP     = 40;
   localparam int unsigned H_SYNC   = 128;
   localparam int unsigned H_BP     = 88;
   localparam int unsigned V_ACTIVE = 600;
   localparam int unsigned V_FP     = 1;
   localparam int unsigned V_SYNC   = 4;
   localparam int unsigned V_BP     = 23;
   localparam int unsigned CNT_W    = 11;

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Sync windows are half-open: [START, END)
   localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

   typedef enum logic {
      ST_WAIT,
      ST_RUN
   } run_state_e;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster position, sync and blanking bundle from the timing generator to the drawing stages.
interface vga_timing_gen_if #(
   parameter int unsigned CNT_W = vga_pkg::CNT_W
);

   logic [CNT_W-1:0] hcount;
   logic [CNT_W-1:0] vcount;
   logic             hsync;
   logic             vsync;
   logic             hblnk;
   logic             vblnk;
   logic             frame_start;

   modport master (
      output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start
   );

   modport slave (
      input hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start
   );

endinterface

// File: rtl/mod_counter.sv
// Modulo-N counter exposing its next value so downstream decode can be registered in step.
module mod_counter #(
   parameter int unsigned MODULUS = 2,
   parameter int unsigned W       = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_inc,
   output logic [W-1:0] o_count,
   output logic [W-1:0] o_next,
   output logic         o_wrap
);

   localparam logic [W-1:0] LAST = W'(MODULUS - 1);

   logic [W-1:0] r_count;

   always_comb begin
      o_wrap = i_inc && (r_count == LAST);
      o_next = r_count;
      if (i_inc) begin
         o_next = o_wrap ? '0 : r_count + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else begin
         r_count <= o_next;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator: pixel/line counters plus registered sync, blank and frame pulse.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int unsigned H_FP     = vga_pkg::H_FP,
   parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
   parameter int unsigned H_BP     = vga_pkg::H_BP,
   parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int unsigned V_FP     = vga_pkg::V_FP,
   parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
   parameter int unsigned V_BP     = vga_pkg::V_BP,
   parameter int unsigned CNT_W    = vga_pkg::CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   vga_timing_gen_if.master    vga
);

   import vga_pkg::*;

   localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] HB_BEG = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VB_BEG = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   run_state_e       r_state;
   run_state_e       w_state_next;
   logic             w_inc;
   logic [CNT_W-1:0] w_h_next;
   logic [CNT_W-1:0] w_v_next;
   logic             w_h_wrap;
   logic             w_v_wrap;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_hblnk;
   logic             r_vblnk;
   logic             r_frame_start;

   // First edge after reset holds (0,0) and announces it; counting begins on the second edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_WAIT;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_inc        = 1'b0;
      case (r_state)
         ST_WAIT: w_state_next = ST_RUN;
         ST_RUN:  w_inc        = 1'b1;
      endcase
   end

   mod_counter #(
      .MODULUS (HT),
      .W       (CNT_W)
   ) u_hcnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_inc),
      .o_count (vga.hcount),
      .o_next  (w_h_next),
      .o_wrap  (w_h_wrap)
   );

   mod_counter #(
      .MODULUS (VT),
      .W       (CNT_W)
   ) u_vcnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_h_wrap),
      .o_count (vga.vcount),
      .o_next  (w_v_next),
      .o_wrap  (w_v_wrap)
   );

   // Decode the next counts so each registered flag lines up with the count it describes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hsync       <= 1'b0;
         r_vsync       <= 1'b0;
         r_hblnk       <= 1'b0;
         r_vblnk       <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_hblnk       <= (w_h_next >= HB_BEG);
         r_hsync       <= (w_h_next >= HS_BEG) && (w_h_next < HS_END);
         r_vblnk       <= (w_v_next >= VB_BEG);
         r_vsync       <= (w_v_next >= VS_BEG) && (w_v_next < VS_END);
         r_frame_start <= (r_state == ST_WAIT) || w_v_wrap;
      end
   end

   assign vga.hsync       = r_hsync;
   assign vga.vsync       = r_vsync;
   assign vga.hblnk       = r_hblnk;
   assign vga.vblnk       = r_vblnk;
   assign vga.frame_start = r_frame_start;

endmodule
